// File: rtl/monitor_defs.sv
// Shared definitions for the monitor control-register bus: register map,
// arbiter state encoding, default write timeout and the arbitration rule.
package monitor_defs;

    localparam int DEFAULT_TIMEOUT = 1000;

    localparam logic [15:0] CTRL_REG_CONTROL = 16'h0000;
    localparam logic [15:0] CTRL_REG_STATUS  = 16'h0001;
    localparam logic [15:0] CTRL_REG_THRESH  = 16'h0002;
    localparam logic [15:0] CTRL_REG_SAMPLE  = 16'h0005;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_READ  = 3'd1;
    localparam state_t ST_RWAIT = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_ACK   = 3'd4;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } bus_cmd_t;

    // Round-robin pick: on contention the master not granted last wins,
    // otherwise whichever master is requesting.
    function automatic logic pick_master(input logic req0, input logic req1,
                                         input logic last_grant);
        return (req0 && req1) ? ~last_grant : req1;
    endfunction

endpackage

// File: rtl/ctrl_bus_timer.sv
// Write-dwell timer: counts cycles while enabled and flags when the
// configured limit is reached, holding there until cleared.
module ctrl_bus_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    assign expired = (count == CW'(TIMEOUT - 1));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ctrl_bus_arbiter.sv
// Two-master round-robin arbiter onto the control-register bus, with a
// bounded-wait write handshake and per-master read-data registers.
module ctrl_bus_arbiter
    import monitor_defs::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [15:0] m1_rdata,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_data_in,
    output logic        bus_read_en,
    output logic        bus_write_en,
    input  logic        bus_write_done,
    input  logic [15:0] bus_data_out,
    output logic        busy
);

    state_t   state;
    state_t   state_nxt;
    logic     last_grant;
    logic     err_q;
    logic     tmr_expired;
    logic     any_req;
    logic     pick;
    bus_cmd_t cmd0;
    bus_cmd_t cmd1;
    bus_cmd_t cmd_sel;

    assign cmd0    = '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
    assign cmd1    = '{we: m1_we, addr: m1_addr, wdata: m1_wdata};
    assign any_req = m0_req | m1_req;
    assign pick    = pick_master(m0_req, m1_req, last_grant);
    assign cmd_sel = pick ? cmd1 : cmd0;

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (any_req) state_nxt = cmd_sel.we ? ST_WRITE : ST_READ;
            ST_READ:  state_nxt = ST_RWAIT;
            ST_RWAIT: state_nxt = ST_ACK;
            ST_WRITE: if (bus_write_done || tmr_expired) state_nxt = ST_ACK;
            ST_ACK:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // last_grant also selects the active master for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            bus_addr    <= '0;
            bus_data_in <= '0;
            err_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && any_req) begin
                last_grant  <= pick;
                bus_addr    <= cmd_sel.addr;
                bus_data_in <= cmd_sel.wdata;
                err_q       <= 1'b0;
            end
            if (state == ST_WRITE) begin
                err_q <= tmr_expired && !bus_write_done;
            end
        end
    end

    // NOTE: read-data registers are plain flops, not a memory, so they take
    // the reset like every other output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else if (state == ST_RWAIT) begin
            if (last_grant) m1_rdata <= bus_data_out;
            else            m0_rdata <= bus_data_out;
        end
    end

    ctrl_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == ST_IDLE),
        .enable  (state == ST_WRITE),
        .expired (tmr_expired)
    );

    // Write strobe drops combinationally on write_done to avoid a second edge.
    assign bus_read_en  = (state == ST_READ);
    assign bus_write_en = (state == ST_WRITE) && !bus_write_done;
    assign busy         = (state != ST_IDLE);
    assign m0_ack       = (state == ST_ACK) && !last_grant;
    assign m1_ack       = (state == ST_ACK) && last_grant;
    assign m0_err       = m0_ack && err_q;
    assign m1_err       = m1_ack && err_q;

endmodule

// File: tb/tb_ctrl_bus_arbiter.sv
// Self-checking bench: directed vector table, randomized transactions against
// a transaction-level model, reset-abort and long-wait write sequences.
module tb_ctrl_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        bus_write_done;
    logic [15:0] bus_data_out;

    logic [1:0]  s_ack, s_err, l_ack, l_err;
    logic [15:0] s_rd0, s_rd1, l_rd0, l_rd1;
    logic [15:0] s_addr, s_din, l_addr, l_din;
    logic        s_ren, s_wen, s_busy, l_ren, l_wen, l_busy;

    logic        sel_long;
    logic [1:0]  obs_ack, obs_err;
    logic [15:0] obs_rd [2];
    logic [15:0] obs_addr, obs_din;
    logic        obs_ren, obs_wen, obs_busy;

    int          checks;
    int          failures;
    logic [15:0] exp_rd [2];

    ctrl_bus_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(s_ack[0]), .m0_err(s_err[0]), .m0_rdata(s_rd0),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(s_ack[1]), .m1_err(s_err[1]), .m1_rdata(s_rd1),
        .bus_addr(s_addr), .bus_data_in(s_din), .bus_read_en(s_ren),
        .bus_write_en(s_wen), .bus_write_done(bus_write_done),
        .bus_data_out(bus_data_out), .busy(s_busy)
    );

    ctrl_bus_arbiter dut_long (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(l_ack[0]), .m0_err(l_err[0]), .m0_rdata(l_rd0),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(l_ack[1]), .m1_err(l_err[1]), .m1_rdata(l_rd1),
        .bus_addr(l_addr), .bus_data_in(l_din), .bus_read_en(l_ren),
        .bus_write_en(l_wen), .bus_write_done(bus_write_done),
        .bus_data_out(bus_data_out), .busy(l_busy)
    );

    assign obs_ack   = sel_long ? l_ack  : s_ack;
    assign obs_err   = sel_long ? l_err  : s_err;
    assign obs_rd[0] = sel_long ? l_rd0  : s_rd0;
    assign obs_rd[1] = sel_long ? l_rd1  : s_rd1;
    assign obs_addr  = sel_long ? l_addr : s_addr;
    assign obs_din   = sel_long ? l_din  : s_din;
    assign obs_ren   = sel_long ? l_ren  : s_ren;
    assign obs_wen   = sel_long ? l_wen  : s_wen;
    assign obs_busy  = sel_long ? l_busy : s_busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [15:0] a0, a1, d0, d1, rdv;
        int          wait_cyc;
        int          win;
        int          lat;
        logic        err;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_flags"}, {25'd0, obs_ack, obs_err, obs_ren, obs_wen, obs_busy}, 32'd0);
        check({tag, "_rd0"}, {16'd0, obs_rd[0]}, 32'd0);
        check({tag, "_rd1"}, {16'd0, obs_rd[1]}, 32'd0);
        check({tag, "_addr"}, {16'd0, obs_addr}, 32'd0);
        check({tag, "_din"}, {16'd0, obs_din}, 32'd0);
    endtask

    task automatic drive_master(input int m, input logic req, input logic we,
                                input logic [15:0] a, input logic [15:0] d);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive_master(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive_master(1, 1'b0, 1'b0, 16'h0, 16'h0);
        bus_write_done = 1'b0;
        bus_data_out   = 16'h0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        exp_rd[0] = 16'h0;
        exp_rd[1] = 16'h0;
        rst_n = 1'b1;
    endtask

    // Caller has just driven the requests inside an IDLE cycle.
    task automatic run_txn(input int tag, input int win, input logic we,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] rdv, input int wait_cyc,
                           input int lat, input logic err_exp);
        string p;
        p = $sformatf("t%0d", tag);
        bus_write_done = 1'b0;
        @(negedge clk);
        check({p, "_idle_busy"}, {31'd0, obs_busy}, 32'd0);
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk);
            #1;
            bus_write_done = we && (c == wait_cyc + 1);
            bus_data_out   = (!we && c == 2) ? rdv : 16'($urandom);
            @(negedge clk);
            p = $sformatf("t%0d_c%0d", tag, c);
            check({p, "_busy"}, {31'd0, obs_busy}, 32'd1);
            check({p, "_ren"}, {31'd0, obs_ren}, {31'd0, !we && c == 1});
            check({p, "_wen"}, {31'd0, obs_wen},
                  {31'd0, we && c <= lat - 1 && c != wait_cyc + 1});
            check({p, "_ack_win"}, {31'd0, obs_ack[win]}, {31'd0, c == lat});
            check({p, "_ack_other"}, {31'd0, obs_ack[1-win]}, 32'd0);
            if (c == 1) begin
                check({p, "_addr"}, {16'd0, obs_addr}, {16'd0, addr});
                check({p, "_din"}, {16'd0, obs_din}, {16'd0, wdata});
            end
            if (c == lat) begin
                if (!we) exp_rd[win] = rdv;
                check({p, "_rdata_win"}, {16'd0, obs_rd[win]}, {16'd0, exp_rd[win]});
                check({p, "_rdata_other"}, {16'd0, obs_rd[1-win]}, {16'd0, exp_rd[1-win]});
                check({p, "_err"}, {31'd0, obs_err[win]}, {31'd0, err_exp});
                check({p, "_err_other"}, {31'd0, obs_err[1-win]}, 32'd0);
                drive_master(win, 1'b0, we, addr, wdata);
            end
        end
        bus_write_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        pend [2];
        logic        pwe  [2];
        logic [15:0] paddr[2];
        logic [15:0] pwd  [2];
        int          last;
        int          win;
        int          w;
        int          d;
        int          tmo;
        vec_t        v;

        checks   = 0;
        failures = 0;
        sel_long = 1'b0;

        //           req    we     a0       a1       d0       d1       rdv      w   win lat err
        vecs[0]  = '{2'b11, 2'b10, 16'h0005, 16'h0002, 16'h0000, 16'h1234, 16'h0ABC, 0, 0, 3, 1'b0};
        vecs[1]  = '{2'b10, 2'b10, 16'h0000, 16'h0002, 16'h0000, 16'h1234, 16'h0000, 1, 1, 3, 1'b0};
        vecs[2]  = '{2'b11, 2'b00, 16'h0010, 16'h0011, 16'h0000, 16'h0000, 16'h1111, 0, 0, 3, 1'b0};
        vecs[3]  = '{2'b11, 2'b00, 16'h0020, 16'h0011, 16'h0000, 16'h0000, 16'h2222, 0, 1, 3, 1'b0};
        vecs[4]  = '{2'b11, 2'b00, 16'h0020, 16'h0021, 16'h0000, 16'h0000, 16'h3333, 0, 0, 3, 1'b0};
        vecs[5]  = '{2'b11, 2'b00, 16'h0030, 16'h0021, 16'h0000, 16'h0000, 16'h4444, 0, 1, 3, 1'b0};
        vecs[6]  = '{2'b01, 2'b00, 16'h0030, 16'h0000, 16'h0000, 16'h0000, 16'h5555, 0, 0, 3, 1'b0};
        vecs[7]  = '{2'b01, 2'b01, 16'h0040, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 7, 0, 9, 1'b0};
        vecs[8]  = '{2'b01, 2'b01, 16'h0041, 16'h0000, 16'hCAFE, 16'h0000, 16'h0000, 20, 0, 9, 1'b1};
        vecs[9]  = '{2'b10, 2'b10, 16'h0000, 16'h0042, 16'h0000, 16'h0F0F, 16'h0000, 0, 1, 2, 1'b0};
        vecs[10] = '{2'b10, 2'b00, 16'h0000, 16'h0043, 16'h0000, 16'h0000, 16'h9999, 0, 1, 3, 1'b0};
        vecs[11] = '{2'b01, 2'b01, 16'h0044, 16'h0000, 16'hA5A5, 16'h0000, 16'h0000, 6, 0, 8, 1'b0};

        apply_reset();

        for (int i = 0; i < 12; i++) begin
            v = vecs[i];
            @(posedge clk);
            #1;
            drive_master(0, v.req[0], v.we[0], v.a0, v.d0);
            drive_master(1, v.req[1], v.we[1], v.a1, v.d1);
            run_txn(i, v.win, v.we[v.win], (v.win == 1) ? v.a1 : v.a0,
                    (v.win == 1) ? v.d1 : v.d0, v.rdv, v.wait_cyc, v.lat, v.err);
        end

        // Randomized traffic against the transaction-level arbitration model.
        apply_reset();
        tmo  = 8;
        last = 1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk);
            #1;
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && $urandom_range(0, 2) != 0) begin
                    pend[m]  = 1'b1;
                    pwe[m]   = 1'($urandom_range(0, 1));
                    paddr[m] = 16'($urandom);
                    pwd[m]   = 16'($urandom);
                end
            end
            if (!pend[0] && !pend[1]) begin
                win        = int'($urandom_range(0, 1));
                pend[win]  = 1'b1;
                pwe[win]   = 1'b0;
                paddr[win] = 16'($urandom);
                pwd[win]   = 16'($urandom);
            end
            for (int m = 0; m < 2; m++) drive_master(m, pend[m], pwe[m], paddr[m], pwd[m]);
            if (pend[0] && pend[1]) win = 1 - last;
            else                    win = pend[0] ? 0 : 1;
            last = win;
            w = int'($urandom_range(0, 12));
            d = (w + 1 <= tmo) ? w + 1 : tmo;
            run_txn(100 + t, win, pwe[win], paddr[win], pwd[win], 16'($urandom), w,
                    pwe[win] ? d + 1 : 3, pwe[win] && (w + 1 > tmo));
            pend[win] = 1'b0;
        end

        // Reset pulsed in the middle of a write aborts it without an ack.
        apply_reset();
        @(posedge clk);
        #1;
        drive_master(0, 1'b1, 1'b1, 16'h0007, 16'h5A5A);
        bus_write_done = 1'b0;
        @(negedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("abort_c%0d_wen", c), {31'd0, obs_wen}, 32'd1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("abort_now");
        drive_master(0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        check_zero("abort_held");
        rst_n = 1'b1;
        exp_rd[0] = 16'h0;
        exp_rd[1] = 16'h0;
        @(posedge clk);
        #1;
        drive_master(0, 1'b1, 1'b0, 16'h0007, 16'h0000);
        run_txn(200, 0, 1'b0, 16'h0007, 16'h0000, 16'h7777, 0, 3, 1'b0);

        // Slow peripheral on the default-timeout instance: 50 wait cycles.
        sel_long = 1'b1;
        apply_reset();
        @(posedge clk);
        #1;
        drive_master(0, 1'b1, 1'b1, 16'h0003, 16'h00AA);
        run_txn(300, 0, 1'b1, 16'h0003, 16'h00AA, 16'h0000, 50, 52, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_bus_arbiter.md
CTRL_BUS_ARBITER -- requirements
Module: ctrl_bus_arbiter

Interface
REQ-001 The block SHALL take the parameter TIMEOUT, default 1000, the maximum number of cycles spent in WRITE before forced completion.
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-004 The block SHALL have ports m0_req, m0_we, input, 1 bit each, master 0 request and write-not-read flag.
REQ-005 The block SHALL have ports m0_addr, m0_wdata, input, 16 bits each, master 0 register address and write data.
REQ-006 The block SHALL have ports m0_ack, m0_err, output, 1 bit each, and m0_rdata, output, 16 bits: completion pulse, timeout flag and read data.
REQ-007 The block SHALL have ports m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err and m1_rdata, identical to the m0_* set, for master 1.
REQ-008 The block SHALL have ports bus_addr, bus_data_in, output, 16 bits each, and bus_read_en, bus_write_en, output, 1 bit each, driving the control-register bus.
REQ-009 The block SHALL have ports bus_write_done, input, 1 bit, and bus_data_out, input, 16 bits, returned by the control-register bus.
REQ-010 The block SHALL have port busy, output, 1 bit, high in any state other than IDLE.

Function
REQ-011 The FSM SHALL have the states IDLE, READ, RWAIT, WRITE and ACK.
REQ-012 Master protocol: a master holds req and its fields stable until its ack; ack is a one-cycle pulse, and rdata/err are valid only while ack is high.
REQ-013 In IDLE with at least one req high, the block SHALL grant one master and register bus_addr and bus_data_in from it; the next state is WRITE if we=1, otherwise READ.
REQ-014 Round-robin: with both req high in IDLE, the master not granted last SHALL win; with one req high, that master wins regardless of history.
REQ-015 READ: bus_read_en SHALL be 1 for exactly this one cycle; the next state is RWAIT.
REQ-016 RWAIT: bus_data_out SHALL be captured into the granted master's rdata at the end of the cycle; the next state is ACK.
REQ-017 WRITE: bus_write_en SHALL equal the combinational value (state==WRITE) AND NOT bus_write_done, so no second write edge follows write_done.
REQ-018 WRITE: bus_write_done high SHALL move the FSM to ACK with err=0; the dwell in WRITE is unbounded up to TIMEOUT, covering peripheral load, read and start sequences.
REQ-019 Timeout: a counter SHALL clear on entry to WRITE and increment each WRITE cycle; when it reaches TIMEOUT-1 without write_done, the next state is ACK with err=1.
REQ-020 bus_write_done and the timeout in the same cycle: write_done SHALL win and err=0.
REQ-021 ACK: the granted master's ack SHALL be 1 for one cycle and the other master's ack SHALL stay 0; the next state is always IDLE, and req is ignored in ACK.
REQ-022 Latency from req sampled in IDLE to ack: read SHALL be 3 cycles; write SHALL be 2 cycles plus the cycles spent waiting for write_done.
REQ-023 The non-granted master's rdata SHALL hold its previous value, and bus_addr/bus_data_in SHALL hold their values until the next grant.
REQ-024 bus_read_en and bus_write_en SHALL never be high in the same cycle.

Reset
REQ-025 While rst_n=0, the FSM SHALL be in IDLE and all outputs SHALL be 0, including rdata and the bus_* outputs.
REQ-026 While rst_n=0, the last-grant register SHALL be 1, so master 0 wins the first contention, and the timeout counter SHALL be 0.
REQ-027 Reset asserted mid-transaction SHALL abort it with no ack; the master re-requests after reset.

Structure
REQ-028 The FSM state encoding and the default TIMEOUT SHALL live in the shared monitor_defs package beside the CTRL_REG_* addresses.
REQ-029 The timeout counter SHALL be a sub-module, ctrl_bus_timer, with clear, enable and expired ports.

Verification
REQ-030 Scenario: m0 read of addr 0x0005, bus_data_out=0x0ABC -> bus_read_en is high 1 cycle; m0_ack=1 with m0_rdata=0x0ABC 3 cycles after grant; m1_ack stays 0.
REQ-031 Scenario: m1 write 0x1234 to addr 0x0002, write_done returned 1 cycle later -> bus_write_en is high exactly 1 cycle; m1_ack=1, m1_err=0.
REQ-032 Scenario: m0 and m1 both request continuously from reset -> grants alternate m0, m1, m0, m1.
REQ-033 Scenario: write with write_done held low, TIMEOUT=8 -> bus_write_en is high 8 cycles; ack=1 with err=1; the FSM returns to IDLE.
REQ-034 Scenario: write_done held low for 50 cycles (peripheral path), TIMEOUT=1000 -> write_en drops on the write_done cycle; ack follows 1 cycle later with err=0.
REQ-035 Scenario: rst_n pulsed low during WRITE -> outputs are 0 immediately with no ack; the next m0 request completes normally.
